// File: rtl/banked_ram_ctl_if.sv
// Bus bundle for banked_ram_ctl: request/data signals from the datapath, read result and status back.
interface banked_ram_ctl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   addr16;
  logic [DATA_W-1:0]   dataIn;
  logic                wrEnable;
  logic [DATA_W/8-1:0] byteEn;
  logic                rdEnable;
  logic                clrReq;
  logic [DATA_W-1:0]   dataOut;
  logic                rdValid;
  logic                busy;

  modport master (
    output addr16, dataIn, wrEnable, byteEn, rdEnable, clrReq,
    input  dataOut, rdValid, busy
  );

  modport slave (
    input  addr16, dataIn, wrEnable, byteEn, rdEnable, clrReq,
    output dataOut, rdValid, busy
  );
endinterface

// File: rtl/banked_ram_ctl.sv
// Banked word RAM with per-byte write enables, 1-cycle registered reads and a clear engine
// that zero-fills every bank in parallel after reset or on request.
module banked_ram_ctl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_BITS = 2,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic              clk,
  input logic              rstN,
  banked_ram_ctl_if.slave  bus
);

  localparam int unsigned NumBanks  = 2 ** BANK_BITS;
  localparam int unsigned OffW      = ADDR_W - BANK_BITS;
  localparam int unsigned BankWords = 2 ** OffW;
  localparam int unsigned NumBytes  = DATA_W / 8;

  typedef enum logic [0:0] {StClear, StIdle} stateT;

  stateT           stateQ, stateD;
  logic [OffW-1:0] clrCntQ, clrCntD;
  logic [DATA_W-1:0] dataOutQ;
  logic              rdValidQ;

  logic [DATA_W-1:0] mem [NumBanks][BankWords];

  logic [BANK_BITS-1:0] bankSel;
  logic [OffW-1:0]      offSel;
  logic [DATA_W-1:0]    oldWord;
  logic [DATA_W-1:0]    mergedWord;
  logic                 wrAcc;
  logic                 rdAcc;

  assign bankSel = bus.addr16[ADDR_W-1 -: BANK_BITS];
  assign offSel  = bus.addr16[OffW-1:0];
  assign oldWord = mem[bankSel][offSel];
  assign wrAcc   = (stateQ == StIdle) && bus.wrEnable && (|bus.byteEn);
  assign rdAcc   = (stateQ == StIdle) && bus.rdEnable;

  // Write-first: a same-cycle read returns the word with this cycle's enabled bytes applied.
  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < NumBytes; i++) begin
      if (bus.wrEnable && bus.byteEn[i]) begin
        mergedWord[8*i +: 8] = bus.dataIn[8*i +: 8];
      end
    end
  end

  always_comb begin
    stateD  = stateQ;
    clrCntD = clrCntQ;
    unique case (stateQ)
      StClear: begin
        clrCntD = clrCntQ + 1'b1;
        if (clrCntQ == '1) begin
          stateD = StIdle;
        end
      end
      StIdle: begin
        if (bus.clrReq) begin
          stateD  = StClear;
          clrCntD = '0;
        end
      end
      default: stateD = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ   <= StClear;
      clrCntQ  <= '0;
      dataOutQ <= '0;
      rdValidQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      clrCntQ  <= clrCntD;
      rdValidQ <= rdAcc;
      if (rdAcc) begin
        dataOutQ <= mergedWord;
      end
    end
  end

  // Array has no reset; the clear engine writes one offset of every bank per cycle.
  always_ff @(posedge clk) begin
    if (stateQ == StClear) begin
      for (int b = 0; b < NumBanks; b++) begin
        mem[b][clrCntQ] <= CLR_VAL;
      end
    end else if (wrAcc) begin
      mem[bankSel][offSel] <= mergedWord;
    end
  end

  assign bus.dataOut = dataOutQ;
  assign bus.rdValid = rdValidQ;
  assign bus.busy    = (stateQ == StClear);

endmodule

// File: tb/tb_banked_ram_ctl.sv
// Directed and randomized checks of banked_ram_ctl (64 words, 4 banks, 16-cycle clear)
// against a flat word-array model.
module tb_banked_ram_ctl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;

  logic [DW-1:0] model [64];
  logic [DW-1:0] expDout;

  banked_ram_ctl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  banked_ram_ctl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .BANK_BITS(2),
    .CLR_VAL  ('0)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    bus.addr16   = '0;
    bus.dataIn   = '0;
    bus.wrEnable = 1'b0;
    bus.byteEn   = '0;
    bus.rdEnable = 1'b0;
    bus.clrReq   = 1'b0;
  endtask

  task automatic modelClear();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // Counts clock edges until busy falls, bounded.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // One idle-state access; the model applies the enabled bytes, write-first for a same-cycle read.
  task automatic doOp(input logic wr, input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be, input string tag);
    logic [DW-1:0] w;
    bus.addr16   = a;
    bus.dataIn   = d;
    bus.wrEnable = wr;
    bus.rdEnable = rd;
    bus.byteEn   = be;
    w = model[a];
    if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      model[a] = w;
    end
    if (rd) expDout = w;
    @(posedge clk);
    #1;
    idleInputs();
    check({tag, ".rdValid"}, 32'(bus.rdValid), 32'(rd));
    check({tag, ".dataOut"}, bus.dataOut, expDout);
  endtask

  task automatic pulseClear();
    bus.clrReq = 1'b1;
    @(posedge clk);
    #1;
    bus.clrReq = 1'b0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    checks   = 0;
    failures = 0;
    expDout  = '0;
    modelClear();
    idleInputs();
    rstN = 1'b0;
    #23;
    check("reset.dataOut", bus.dataOut, 32'h0);
    check("reset.rdValid", 32'(bus.rdValid), 32'h0);
    check("reset.busy", 32'(bus.busy), 32'h1);

    // 1. Initial clear length and zeroed bank bases
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("t1.busyAtRelease", 32'(bus.busy), 32'h1);
    waitIdle(n);
    check("t1.clearCycles", 32'(n), 32'd16);
    doOp(1'b0, 1'b1, 6'h00, '0, 4'h0, "t1.rd00");
    doOp(1'b0, 1'b1, 6'h10, '0, 4'h0, "t1.rd10");
    doOp(1'b0, 1'b1, 6'h20, '0, 4'h0, "t1.rd20");
    doOp(1'b0, 1'b1, 6'h30, '0, 4'h0, "t1.rd30");

    // 2. Same offset in every bank, then isolation
    for (int b = 0; b < 4; b++) doOp(1'b1, 1'b0, 6'(16*b + 3), 32'hCAFECAFE, 4'hF, "t2.wr");
    for (int b = 0; b < 4; b++) begin
      doOp(1'b0, 1'b1, 6'(16*b + 3), '0, 4'h0, "t2.rd");
      check("t2.const", bus.dataOut, 32'hCAFECAFE);
    end
    doOp(1'b0, 1'b1, 6'h04, '0, 4'h0, "t2.rd04");
    check("t2.rd04const", bus.dataOut, 32'h0);

    // 3. Partial byte write
    doOp(1'b1, 1'b0, 6'h13, 32'hBEBEBEBE, 4'b0011, "t3.wr13");
    doOp(1'b0, 1'b1, 6'h13, '0, 4'h0, "t3.rd13");
    check("t3.rd13const", bus.dataOut, 32'hCAFEBEBE);
    doOp(1'b0, 1'b1, 6'h03, '0, 4'h0, "t3.rd03");
    check("t3.rd03const", bus.dataOut, 32'hCAFECAFE);

    // 4. Same-cycle read/write is write-first
    doOp(1'b1, 1'b1, 6'h23, 32'h12345678, 4'b1000, "t4.rdwr23");
    check("t4.const", bus.dataOut, 32'h12FECAFE);
    doOp(1'b0, 1'b0, 6'h23, '0, 4'h0, "t4.hold");

    // Randomized idle traffic
    for (int k = 0; k < 120; k++) begin
      a = 6'($urandom_range(0, 63));
      doOp(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom), "rand");
    end

    // 5. Requests during a clear are lost
    pulseClear();
    modelClear();
    check("t5.busy", 32'(bus.busy), 32'h1);
    bus.addr16   = 6'h33;
    bus.dataIn   = 32'hFFFFFFFF;
    bus.byteEn   = 4'hF;
    bus.wrEnable = 1'b1;
    bus.rdEnable = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      check("t5.rdValidBusy", 32'(bus.rdValid), 32'h0);
    end
    idleInputs();
    check("t5.clearCycles", 32'(n), 32'd16);
    check("t5.dataOutHeld", bus.dataOut, expDout);
    doOp(1'b0, 1'b1, 6'h33, '0, 4'h0, "t5.rd33");
    check("t5.rd33const", bus.dataOut, 32'h0);

    // 6. Reset in the middle of a clear
    doOp(1'b1, 1'b1, 6'h05, 32'hA5A55A5A, 4'hF, "t6.prep");
    pulseClear();
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rstN = 1'b0;
    #1;
    check("t6.asyncDataOut", bus.dataOut, 32'h0);
    check("t6.asyncRdValid", 32'(bus.rdValid), 32'h0);
    check("t6.asyncBusy", 32'(bus.busy), 32'h1);
    expDout = '0;
    modelClear();
    @(negedge clk);
    rstN = 1'b1;
    #1;
    waitIdle(n);
    check("t6.clearCycles", 32'(n), 32'd16);
    doOp(1'b0, 1'b1, 6'h05, '0, 4'h0, "t6.rd05");
    doOp(1'b0, 1'b1, 6'h23, '0, 4'h0, "t6.rd23");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
